// File: rtl/fe_pkg.sv
// Shared fetch-side definitions: loader state encoding and RV32I fetch constants.
package fe_pkg;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        RUN      = 2'd1,
        OVERFLOW = 2'd2
    } imem_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] RV32I_NOP      = 32'h0000_0013;
    localparam logic [31:0] IMEM_BASE_ADDR = 32'h0400_0000;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; zero-pads a short final word.
module imem_byte_packer
    import fe_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    output logic        o_word_valid,
    output logic [31:0] o_word_data,
    output logic [1:0]  o_byte_cnt
);

    logic [1:0]  r_byte_cnt;
    logic [23:0] r_partial;

    // Place the incoming byte in its lane; lanes above it are zero so a short last word is padded.
    always_comb begin
        o_word_valid = i_accept && (i_last || (r_byte_cnt == 2'd3));
        o_byte_cnt   = r_byte_cnt;
        o_word_data  = 32'h0;
        case (r_byte_cnt)
            2'd0:    o_word_data = {24'h0, i_byte};
            2'd1:    o_word_data = {16'h0, i_byte, r_partial[7:0]};
            2'd2:    o_word_data = {8'h0, i_byte, r_partial[15:0]};
            default: o_word_data = {i_byte, r_partial};
        endcase
    end

    // Byte counter and partial-word register; both clear when a word is emitted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte_cnt <= 2'd0;
            r_partial  <= 24'h0;
        end else if (i_accept) begin
            if (o_word_valid) begin
                r_byte_cnt <= 2'd0;
                r_partial  <= 24'h0;
            end else begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0:    r_partial[7:0]   <= i_byte;
                    2'd1:    r_partial[15:8]  <= i_byte;
                    default: r_partial[23:16] <= i_byte;
                endcase
            end
        end
    end

endmodule

// File: rtl/rv32i_imem_loader.sv
// Instruction memory for the single-cycle core: byte-stream loader, then combinational fetch.
module rv32i_imem_loader
    import fe_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
    parameter logic [31:0] NOP_INSTR = RV32I_NOP,
    localparam int unsigned CntW     = $clog2(DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load_valid,
    input  logic [7:0]      i_load_byte,
    input  logic            i_load_last,
    output logic            o_load_ready,
    input  logic [31:0]     i_program_counter_s1,
    output logic [31:0]     o_raw_bits,
    output logic            o_core_run,
    output logic            o_fetch_fault,
    output logic            o_load_overflow,
    output logic [CntW-1:0] o_words_loaded
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    imem_state_e     r_state;
    imem_state_e     w_state_next;
    logic [CntW-1:0] r_words_loaded;
    logic [31:0]     r_mem [DEPTH];

    logic            w_transfer;
    logic            w_overflow_hit;
    logic            w_pack_accept;
    logic            w_word_valid;
    logic [31:0]     w_word_data;
    logic [1:0]      w_byte_cnt;
    logic [31:0]     w_offset;
    logic [29:0]     w_idx;
    logic            w_fetch_valid;

    imem_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_accept     (w_pack_accept),
        .i_byte       (i_load_byte),
        .i_last       (i_load_last),
        .o_word_valid (w_word_valid),
        .o_word_data  (w_word_data),
        .o_byte_cnt   (w_byte_cnt)
    );

    // Handshake decode; a byte starting a word beyond DEPTH is dropped and trips overflow.
    always_comb begin
        o_load_ready   = (r_state == LOAD);
        o_core_run     = (r_state == RUN);
        o_load_overflow = (r_state == OVERFLOW);
        o_words_loaded = r_words_loaded;
        w_transfer     = i_load_valid && o_load_ready;
        w_overflow_hit = w_transfer && (r_words_loaded == CntW'(DEPTH)) && (w_byte_cnt == 2'd0);
        w_pack_accept  = w_transfer && !w_overflow_hit;
    end

    // Next-state logic: RUN and OVERFLOW are left only through reset.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD: begin
                if (w_overflow_hit) begin
                    w_state_next = OVERFLOW;
                end else if (w_pack_accept && i_load_last) begin
                    w_state_next = RUN;
                end
            end
            RUN:      w_state_next = RUN;
            OVERFLOW: w_state_next = OVERFLOW;
            default:  w_state_next = LOAD;
        endcase
    end

    // State and word-count registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= LOAD;
            r_words_loaded <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_word_valid) begin
                r_words_loaded <= r_words_loaded + 1'b1;
            end
        end
    end

    // Storage write port; contents survive reset since words_loaded gates every read.
    always_ff @(posedge i_clk) begin
        if (w_word_valid) begin
            r_mem[r_words_loaded[AW-1:0]] <= w_word_data;
        end
    end

    // Combinational fetch so the single-cycle core sees the instruction in the same cycle.
    always_comb begin
        w_offset      = i_program_counter_s1 - BASE_ADDR;
        w_idx         = 30'(w_offset >> 2);
        w_fetch_valid = o_core_run && (i_program_counter_s1[1:0] == 2'b00) &&
                        (i_program_counter_s1 >= BASE_ADDR) &&
                        ({2'b00, w_idx} < 32'(r_words_loaded));
        o_raw_bits    = w_fetch_valid ? r_mem[w_idx[AW-1:0]] : NOP_INSTR;
        o_fetch_fault = o_core_run && !w_fetch_valid;
    end

endmodule

// File: tb/tb_rv32i_imem_loader.sv
// Scoreboard bench: stimulus queues expected observations, a negedge monitor checks them.
module tb_rv32i_imem_loader;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam logic [31:0] BASE  = 32'h0400_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     raw;
        logic            fault;
        logic            run;
        logic            ready;
        logic            ovf;
        logic [CntW-1:0] words;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_valid;
    logic [7:0]      load_byte;
    logic            load_last;
    logic            load_ready;
    logic [31:0]     pc;
    logic [31:0]     raw_bits;
    logic            core_run;
    logic            fetch_fault;
    logic            load_overflow;
    logic [CntW-1:0] words_loaded;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    rv32i_imem_loader #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .NOP_INSTR (NOP)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_load_valid         (load_valid),
        .i_load_byte          (load_byte),
        .i_load_last          (load_last),
        .o_load_ready         (load_ready),
        .i_program_counter_s1 (pc),
        .o_raw_bits           (raw_bits),
        .o_core_run           (core_run),
        .o_fetch_fault        (fetch_fault),
        .o_load_overflow      (load_overflow),
        .o_words_loaded       (words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic cmp(input string n, input string f, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: actual=%08h required=%08h", n, f, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle while any are pending.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                cmp(n, "raw_bits", raw_bits, e.raw);
                cmp(n, "fetch_fault", 32'(fetch_fault), 32'(e.fault));
                cmp(n, "core_run", 32'(core_run), 32'(e.run));
                cmp(n, "load_ready", 32'(load_ready), 32'(e.ready));
                cmp(n, "load_overflow", 32'(load_overflow), 32'(e.ovf));
                cmp(n, "words_loaded", 32'(words_loaded), 32'(e.words));
            end
        end
    end

    task automatic expect_at(input string n, input logic [31:0] addr, input logic [31:0] raw,
                             input logic fault, input logic run, input logic ready,
                             input logic ovf, input int unsigned words);
        exp_t e;
        pc      = addr;
        e.raw   = raw;
        e.fault = fault;
        e.run   = run;
        e.ready = ready;
        e.ovf   = ovf;
        e.words = CntW'(words);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic gap);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] prog1 [8];

    initial begin
        prog1 = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        rst        = 1'b1;
        load_valid = 1'b0;
        load_byte  = 8'h00;
        load_last  = 1'b0;
        pc         = BASE;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        expect_at("reset", BASE, NOP, 0, 0, 1, 0, 0);

        // Two-word program with idle gaps between bytes.
        for (int i = 0; i < 7; i++) send_byte(prog1[i], 1'b0, (i % 2) == 0);
        expect_at("before_last", BASE, NOP, 0, 0, 1, 0, 1);
        send_byte(prog1[7], 1'b1, 1'b0);
        expect_at("fetch_w0", BASE, 32'h00A0_0513, 0, 1, 0, 0, 2);
        expect_at("fetch_w1", BASE + 4, 32'h0010_0593, 0, 1, 0, 0, 2);
        expect_at("misaligned", BASE + 2, NOP, 1, 1, 0, 0, 2);
        expect_at("past_end", BASE + 8, NOP, 1, 1, 0, 0, 2);
        expect_at("below_base", 32'h03FF_FFFC, NOP, 1, 1, 0, 0, 2);

        // Bytes offered during RUN must be ignored.
        load_valid = 1'b1;
        load_byte  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        load_valid = 1'b0;
        expect_at("run_ignore", BASE, 32'h00A0_0513, 0, 1, 0, 0, 2);

        // Reset from RUN, then a fresh one-word program.
        pulse_reset();
        expect_at("reset_run", BASE, NOP, 0, 0, 1, 0, 0);
        send_byte(8'hEF, 1'b0, 1'b0);
        send_byte(8'hBE, 1'b0, 1'b0);
        send_byte(8'hAD, 1'b0, 1'b0);
        send_byte(8'hDE, 1'b1, 1'b0);
        expect_at("reload_w0", BASE, 32'hDEAD_BEEF, 0, 1, 0, 0, 1);
        expect_at("reload_stale", BASE + 4, NOP, 1, 1, 0, 0, 1);

        // Last byte in lane 0 of the second word.
        pulse_reset();
        for (int i = 0; i < 4; i++) send_byte(prog1[i], 1'b0, 1'b0);
        send_byte(8'h6F, 1'b1, 1'b0);
        expect_at("partial_w0", BASE, 32'h00A0_0513, 0, 1, 0, 0, 2);
        expect_at("partial_w1", BASE + 4, 32'h0000_006F, 0, 1, 0, 0, 2);

        // Last byte in lane 2.
        pulse_reset();
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        expect_at("pad_lane2", BASE, 32'h0033_2211, 0, 1, 0, 0, 1);

        // Overflow: 16 bytes fill DEPTH=4 words, byte 17 trips it.
        pulse_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
        expect_at("full", BASE, NOP, 0, 0, 1, 0, 4);
        send_byte(8'hAA, 1'b0, 1'b0);
        expect_at("overflow", BASE, NOP, 0, 0, 0, 1, 4);
        send_byte(8'hBB, 1'b1, 1'b0);
        expect_at("overflow_sticky", BASE, NOP, 0, 0, 0, 1, 4);
        pulse_reset();
        expect_at("overflow_reset", BASE, NOP, 0, 0, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_imem_loader.md
Name: rv32i_imem_loader

Overview:
Instruction-memory responder on the fetch side of RV32I_core. It serves `raw_bits` for the core's `program_counter_s1`.
- Before the core runs, it accepts the program as a little-endian byte stream with a valid/ready handshake.
- It assembles the bytes into 32-bit words and stores them.
- Once the last byte is accepted it releases the core and answers fetches combinationally, so the single-cycle core sees the instruction in the same cycle.

Parameters:
- DEPTH, 1024, instruction words of storage.
- BASE_ADDR, 32'h0400_0000, byte address of word 0.
- NOP_INSTR, 32'h0000_0013, value returned for any invalid fetch (`addi x0,x0,0`).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  a load byte is present.
- load_byte  in  8  program byte.
- load_last  in  1  qualifies `load_byte` as the final program byte.
- load_ready  out  1  loader accepts a byte this cycle.
- program_counter_s1  in  32  fetch byte address from the core.
- raw_bits  out  32  instruction returned to the core.
- core_run  out  1  1 = core may execute; the core is held while 0.
- fetch_fault  out  1  current fetch is misaligned or out of range.
- load_overflow  out  1  sticky; program exceeded DEPTH.
- words_loaded  out  $clog2(DEPTH+1)  number of valid words.

Behaviour:
- **States:** LOAD, RUN, OVERFLOW. The state, byte counter (2 bits), partial-word register (24 bits) and `words_loaded` are registered. Clock is `clk`; `rst` is synchronous and active-high.
- **Reset values:** state = LOAD, byte counter = 0, partial = 0, `words_loaded` = 0, `load_overflow` = 0, `core_run` = 0.
  - Reset in any state, including mid-word or in RUN, returns to exactly these values.
  - Memory contents are not cleared; stale words are unreachable because `words_loaded` = 0.
- **Ready:** `load_ready` = 1 only in LOAD. A transfer is `load_valid && load_ready` sampled at posedge `clk`.
- **LOAD byte packing:** the accepted byte goes to lane byte_cnt; lane 0 = bits 7:0, little-endian. byte_cnt then increments and wraps 3→0.
- **LOAD word write:** on the transfer with byte_cnt = 3, the assembled word {byte, partial} is written to `mem[words_loaded]` and `words_loaded` increments, both at the same edge.
- **load_last with byte_cnt < 3:** the remaining upper lanes are zero-padded and the word is written the same edge. State goes to RUN and byte_cnt to 0.
- **load_last with byte_cnt = 3:** normal write, then RUN.
- **RUN timing:** `core_run` = 1 starting the cycle after the edge that accepts `load_last`.
- **Overflow:** a transfer arriving when `words_loaded` == DEPTH and byte_cnt = 0 is not written. State goes to OVERFLOW: `load_overflow` = 1, `load_ready` = 0, `core_run` = 0. Only `rst` exits OVERFLOW.
- **load_valid with load_ready = 0:** the byte is ignored and nothing changes.
- **Fetch (combinational):**
  - idx = (`program_counter_s1` − BASE_ADDR) >> 2, 32-bit unsigned subtraction.
  - valid = `core_run` && pc[1:0] == 0 && pc ≥ BASE_ADDR && idx < `words_loaded`.
  - `raw_bits` = valid ? mem[idx] : NOP_INSTR.
  - `fetch_fault` = `core_run` && !valid.
  - While `core_run` = 0: `raw_bits` = NOP_INSTR and `fetch_fault` = 0.
- **Write/read collision:** impossible, since writes occur only in LOAD and reads are valid only in RUN.
- **Memory:** DEPTH × 32, one write port and one asynchronous read port.

Decomposition:
- The shared package `fe_pkg` gains:
  - the state enum `imem_state_e` {LOAD, RUN, OVERFLOW};
  - the constants RV32I_NOP (32'h0000_0013) and IMEM_BASE_ADDR (32'h0400_0000).
- Sub-module `imem_byte_packer`: byte counter plus partial register. Outputs `word_valid` and `word_data`; handles zero-padding on last. The top level holds the FSM, memory and fetch decode.

Test Plan:
- **Basic load and fetch:** 8 bytes 13 05 A0 00 93 05 10 00, `load_last` on byte 8 → `words_loaded` = 2. `core_run` rises the next cycle. pc 0x0400_0000 → 0x00A0_0513; pc 0x0400_0004 → 0x0010_0593; `fetch_fault` = 0.
- **Partial last word:** 5 bytes 13 05 A0 00 6F, last on the 5th → `words_loaded` = 2 and word1 = 0x0000_006F.
- **Backpressure and idle gaps:** `load_valid` toggled 1/0/1 during load → identical memory image. During RUN, `load_valid` = 1 with any byte → no change to `words_loaded`.
- **Invalid fetches:** after the 2-word load, pc 0x0400_0002, 0x0400_0008 and 0x03FF_FFFC → `raw_bits` = 0x0000_0013 and `fetch_fault` = 1 for each.
- **Overflow:** with DEPTH = 4, send 17 bytes (no last) → after byte 17, `load_overflow` = 1, `load_ready` = 0, `core_run` = 0, `words_loaded` = 4.
- **Reset mid-run:** in RUN, assert `rst` for 1 cycle → `core_run` = 0, `words_loaded` = 0, `load_ready` = 1, `raw_bits` = NOP. Reload 4 bytes → the new word is fetched correctly.
